// File: rtl/dep_issue_scheduler_pkg.sv
// Shared types for the dependency-tracking issue scheduler: the per-slot
// lifecycle encoding and the default instruction-buffer depth.
package dep_issue_scheduler_pkg;

   localparam int BS = 16;

   typedef enum logic [1:0] {
      FREE   = 2'd0,
      WAIT   = 2'd1,
      ISSUED = 2'd2
   } slot_state_t;

endpackage

// File: rtl/dep_issue_scheduler_if.sv
// Allocation, issue handshake, completion and status signals between the
// scheduler (slave) and its IRT / execution-side environment (master).
interface dep_issue_scheduler_if
   import dep_issue_scheduler_pkg::*;
   #(parameter int bs = BS);

   localparam int bs_bits = $clog2(bs);

   logic               alloc_valid;
   logic [bs_bits-1:0] alloc_index;
   logic [bs-1:0]      alloc_deps;
   logic               issue_valid;
   logic [bs_bits-1:0] issue_index;
   logic               issue_ready;
   logic               complete_valid;
   logic [bs_bits-1:0] complete_index;
   logic [bs-1:0]      busy_vec;
   logic               err_alloc;
   logic               err_cmpl;

   modport master (
      output alloc_valid, alloc_index, alloc_deps,
      output issue_ready,
      output complete_valid, complete_index,
      input  issue_valid, issue_index,
      input  busy_vec, err_alloc, err_cmpl
   );

   modport slave (
      input  alloc_valid, alloc_index, alloc_deps,
      input  issue_ready,
      input  complete_valid, complete_index,
      output issue_valid, issue_index,
      output busy_vec, err_alloc, err_cmpl
   );

endinterface

// File: rtl/dep_issue_scheduler_rr_picker.sv
// Combinational round-robin picker: grants the first requesting slot at or
// after ptr, wrapping from bs-1 back to 0.
module rr_picker
   import dep_issue_scheduler_pkg::*;
   #(parameter int bs = BS)
   (
      input  logic [bs-1:0]         req,
      input  logic [$clog2(bs)-1:0] ptr,
      output logic                  gnt_valid,
      output logic [$clog2(bs)-1:0] gnt_index
   );

   localparam int bs_bits = $clog2(bs);

   logic [2*bs-2:0]    dbl;
   logic [bs-1:0]      rot;
   logic [bs_bits-1:0] off;

   // Doubling the request vector turns the wrap-around search into a plain
   // window select followed by a lowest-set-bit encode.
   always_comb begin
      dbl       = {req[bs-2:0], req};
      rot       = dbl[ptr +: bs];
      off       = '0;
      gnt_valid = 1'b0;
      for (int k = bs - 1; k >= 0; k--) begin
         if (rot[k]) begin
            gnt_valid = 1'b1;
            off       = k[bs_bits-1:0];
         end
      end
      gnt_index = ptr + off;
   end

endmodule

// File: rtl/dep_issue_scheduler.sv
// Holds one dependency row per instruction-buffer slot and issues slots whose
// producers have all completed, one per cycle, in round-robin order.
module dep_issue_scheduler
   import dep_issue_scheduler_pkg::*;
   #(parameter int bs = BS)
   (
      input logic             clk,
      input logic             rst,
      dep_issue_scheduler_if.slave bus
   );

   localparam int bs_bits = $clog2(bs);

   slot_state_t        state     [bs];
   slot_state_t        state_nxt [bs];
   logic [bs-1:0]      row       [bs];
   logic [bs-1:0]      row_nxt   [bs];
   logic [bs_bits-1:0] rr_ptr;
   logic [bs-1:0]      ready;
   logic [bs-1:0]      busy;
   logic [bs-1:0]      alloc_row;
   logic [bs-1:0]      cmpl_col;
   logic               gnt_valid;
   logic [bs_bits-1:0] gnt_index;
   logic               xfer;
   logic               alloc_ok;
   logic               cmpl_ok;
   logic               err_alloc_q;
   logic               err_cmpl_q;

   function automatic logic [bs-1:0] slot_bit(input logic [bs_bits-1:0] idx);
      logic [bs-1:0] v;
      v      = '0;
      v[idx] = 1'b1;
      return v;
   endfunction

   always_comb begin
      busy  = '0;
      ready = '0;
      for (int i = 0; i < bs; i++) begin
         busy[i]  = (state[i] != FREE);
         ready[i] = (state[i] == WAIT) && (row[i] == '0);
      end
   end

   rr_picker #(.bs(bs)) u_picker (
      .req       (ready),
      .ptr       (rr_ptr),
      .gnt_valid (gnt_valid),
      .gnt_index (gnt_index)
   );

   assign xfer     = gnt_valid & bus.issue_ready;
   assign alloc_ok = bus.alloc_valid && (state[bus.alloc_index] == FREE);
   assign cmpl_ok  = bus.complete_valid && (state[bus.complete_index] == ISSUED);
   assign cmpl_col = bus.complete_valid ? slot_bit(bus.complete_index) : '0;

   // Stale IRT columns (self, free slots, the slot completing right now) must
   // never become dependencies, or the new instruction could wait forever.
   assign alloc_row = bus.alloc_deps & busy & ~slot_bit(bus.alloc_index) & ~cmpl_col;

   always_comb begin
      for (int i = 0; i < bs; i++) begin
         state_nxt[i] = state[i];
         row_nxt[i]   = cmpl_ok ? (row[i] & ~slot_bit(bus.complete_index)) : row[i];
      end
      if (cmpl_ok) begin
         state_nxt[bus.complete_index] = FREE;
      end
      if (xfer) begin
         state_nxt[gnt_index] = ISSUED;
      end
      if (alloc_ok) begin
         state_nxt[bus.alloc_index] = WAIT;
         row_nxt[bus.alloc_index]   = alloc_row;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < bs; i++) begin
            state[i] <= FREE;
            row[i]   <= '0;
         end
         rr_ptr      <= '0;
         err_alloc_q <= 1'b0;
         err_cmpl_q  <= 1'b0;
      end else begin
         for (int i = 0; i < bs; i++) begin
            state[i] <= state_nxt[i];
            row[i]   <= row_nxt[i];
         end
         if (xfer) begin
            rr_ptr <= gnt_index + bs_bits'(1);
         end
         err_alloc_q <= bus.alloc_valid & ~alloc_ok;
         err_cmpl_q  <= bus.complete_valid & ~cmpl_ok;
      end
   end

   assign bus.issue_valid = gnt_valid;
   assign bus.issue_index = gnt_index;
   assign bus.busy_vec    = busy;
   assign bus.err_alloc   = err_alloc_q;
   assign bus.err_cmpl    = err_cmpl_q;

endmodule
